// File: rtl/sigma_delta_ctrl.sv
// Non-pipelined sequencer feeding sigma_delta_update from the background-model RAM.
// Define SD_CTRL_BG_INIT_EN to seed the model from the first complete frame after reset.
module sigma_delta_ctrl #(
    parameter int unsigned IMG_W         = 320,
    parameter int unsigned IMG_H         = 240,
    parameter int unsigned UPDATE_PERIOD = 4,
    parameter int unsigned SD_LAT        = 1,
    parameter int unsigned ADDR_W        = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              pix_sof,
    input  logic [7:0]        pix_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_bg,
    input  logic [7:0]        mem_rd_var,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_bg,
    output logic [7:0]        mem_wr_var,
    output logic              sd_enable,
    output logic              sd_wr_background,
    output logic [7:0]        sd_curr_pixel,
    output logic [7:0]        sd_background,
    output logic [7:0]        sd_variance,
    input  logic [7:0]        sd_background_next,
    input  logic [7:0]        sd_variance_next,
    input  logic              sd_motion_detected,
    output logic              mask_valid,
    output logic              mask_bit,
    output logic              frame_done
);

    localparam int unsigned NUM_PIX   = IMG_W * IMG_H;
    localparam int unsigned FIDX_W    = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam int unsigned WCNT_W    = (SD_LAT > 2) ? $clog2(SD_LAT - 1) : 1;
    localparam int unsigned WAIT_LAST = (SD_LAT > 1) ? SD_LAT - 2 : 0;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
    localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(UPDATE_PERIOD - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_LAST);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCalc,
        StWait,
        StWb
    } state_e;

    state_e              state_q;
    logic [FIDX_W-1:0]   frame_idx_q;
    logic [FIDX_W-1:0]   frame_idx_next;
    logic [WCNT_W-1:0]   wait_cnt_q;
    logic [7:0]          pix_q;
    logic [7:0]          bg_q;
    logic [7:0]          var_q;
    logic                init_q;
    logic                frame_wrap;

    assign frame_wrap     = (state_q == StWb) && (mem_addr == LAST_ADDR);
    assign frame_idx_next = (frame_idx_q == FIDX_LAST) ? '0 : frame_idx_q + FIDX_W'(1);

    // RAM read data is only valid during CALC, so operands come straight from the RAM
    // then and from the captured copy for the rest of the evaluation.
    assign sd_curr_pixel = pix_q;
    assign sd_background = (state_q == StCalc) ? mem_rd_bg  : bg_q;
    assign sd_variance   = (state_q == StCalc) ? mem_rd_var : var_q;

    always_comb begin
        mem_wr_bg  = 8'd0;
        mem_wr_var = 8'd0;
        mask_bit   = 1'b0;
        if (state_q == StWb) begin
            if (init_q) begin
                mem_wr_bg  = pix_q;
                mem_wr_var = 8'd1;
            end else begin
                mem_wr_bg  = sd_background_next;
                mem_wr_var = sd_variance_next;
                mask_bit   = sd_motion_detected;
            end
        end
    end

`ifdef SD_CTRL_BG_INIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q <= 1'b1;
        end else if (frame_wrap) begin
            init_q <= 1'b0;
        end
    end
`else
    assign init_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            mem_addr         <= '0;
            frame_idx_q      <= '0;
            wait_cnt_q       <= '0;
            pix_q            <= '0;
            bg_q             <= '0;
            var_q            <= '0;
            pix_ready        <= 1'b0;
            mem_rd_en        <= 1'b0;
            mem_wr_en        <= 1'b0;
            sd_enable        <= 1'b0;
            sd_wr_background <= 1'b0;
            mask_valid       <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            mem_rd_en        <= 1'b0;
            mem_wr_en        <= 1'b0;
            sd_enable        <= 1'b0;
            mask_valid       <= 1'b0;
            frame_done       <= 1'b0;
            sd_wr_background <= (frame_idx_q == '0);
            case (state_q)
                StIdle: begin
                    pix_ready <= 1'b1;
                    if (pix_valid && pix_ready) begin
                        pix_q     <= pix_data;
                        pix_ready <= 1'b0;
                        // A start-of-frame mid-frame abandons the frame without frame_done.
                        if (pix_sof) begin
                            mem_addr <= '0;
                        end
                        if (init_q) begin
                            state_q    <= StWb;
                            mem_wr_en  <= 1'b1;
                            mask_valid <= 1'b1;
                        end else begin
                            state_q   <= StRd;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    state_q   <= StCalc;
                    sd_enable <= 1'b1;
                end
                StCalc: begin
                    bg_q       <= mem_rd_bg;
                    var_q      <= mem_rd_var;
                    wait_cnt_q <= '0;
                    if (SD_LAT > 1) begin
                        state_q <= StWait;
                    end else begin
                        state_q    <= StWb;
                        mem_wr_en  <= 1'b1;
                        mask_valid <= 1'b1;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == WCNT_LAST) begin
                        state_q    <= StWb;
                        mem_wr_en  <= 1'b1;
                        mask_valid <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                    end
                end
                StWb: begin
                    state_q   <= StIdle;
                    pix_ready <= 1'b1;
                    if (frame_wrap) begin
                        mem_addr         <= '0;
                        frame_done       <= 1'b1;
                        frame_idx_q      <= frame_idx_next;
                        sd_wr_background <= (frame_idx_next == '0);
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigma_delta_ctrl.sv
// Scoreboard bench for sigma_delta_ctrl: random pixels, RAM and datapath stand-ins,
// and a frame-level reference model of addresses, model contents and timing.
module tb_sigma_delta_ctrl;

    localparam int IMG_W         = 4;
    localparam int IMG_H         = 2;
    localparam int NPIX          = IMG_W * IMG_H;
    localparam int UPDATE_PERIOD = 4;
    localparam int SD_LAT        = 3;
    localparam int ADDR_W        = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic              pix_sof = 1'b0;
    logic [7:0]        pix_data = 8'd0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_bg;
    logic [7:0]        mem_rd_var;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_bg;
    logic [7:0]        mem_wr_var;
    logic              sd_enable;
    logic              sd_wr_background;
    logic [7:0]        sd_curr_pixel;
    logic [7:0]        sd_background;
    logic [7:0]        sd_variance;
    logic [7:0]        sd_background_next;
    logic [7:0]        sd_variance_next;
    logic              sd_motion_detected;
    logic              mask_valid;
    logic              mask_bit;
    logic              frame_done;

    sigma_delta_ctrl #(
        .IMG_W        (IMG_W),
        .IMG_H        (IMG_H),
        .UPDATE_PERIOD(UPDATE_PERIOD),
        .SD_LAT       (SD_LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_sof           (pix_sof),
        .pix_data          (pix_data),
        .mem_addr          (mem_addr),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_bg         (mem_rd_bg),
        .mem_rd_var        (mem_rd_var),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_bg         (mem_wr_bg),
        .mem_wr_var        (mem_wr_var),
        .sd_enable         (sd_enable),
        .sd_wr_background  (sd_wr_background),
        .sd_curr_pixel     (sd_curr_pixel),
        .sd_background     (sd_background),
        .sd_variance       (sd_variance),
        .sd_background_next(sd_background_next),
        .sd_variance_next  (sd_variance_next),
        .sd_motion_detected(sd_motion_detected),
        .mask_valid        (mask_valid),
        .mask_bit          (mask_bit),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Simple sigma-delta step used as the datapath stand-in and by the reference model.
    function automatic logic [16:0] sd_ref(input logic [7:0] p, input logic [7:0] b,
                                           input logic [7:0] v);
        logic [7:0] nb, nv, d;
        nb = b;
        if (p > b) nb = b + 8'd1;
        else if (p < b) nb = b - 8'd1;
        d = (p > b) ? p - b : b - p;
        nv = v;
        if (d != 8'd0) begin
            if ({1'b0, v} < {d, 1'b0}) begin
                if (v != 8'hFF) nv = v + 8'd1;
            end else if ({1'b0, v} > {d, 1'b0}) begin
                if (v > 8'd1) nv = v - 8'd1;
            end
        end
        return {nb, nv, (d > v)};
    endfunction

    // Model RAM: one-cycle read latency, loaded from seed arrays while ram_load is high.
    logic [7:0] seed_bg[NPIX];
    logic [7:0] seed_var[NPIX];
    logic [7:0] ram_bg[NPIX];
    logic [7:0] ram_var[NPIX];
    logic       ram_load = 1'b1;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < NPIX; i++) begin
                ram_bg[i]  <= seed_bg[i];
                ram_var[i] <= seed_var[i];
            end
        end else begin
            if (mem_rd_en) begin
                mem_rd_bg  <= ram_bg[mem_addr];
                mem_rd_var <= ram_var[mem_addr];
            end
            if (mem_wr_en) begin
                ram_bg[mem_addr]  <= mem_wr_bg;
                ram_var[mem_addr] <= mem_wr_var;
            end
        end
    end

    // Datapath stand-in: result appears SD_LAT cycles after sd_enable and then holds.
    logic [16:0] stg[SD_LAT];
    always @(posedge clk) begin
        if (sd_enable) stg[0] <= sd_ref(sd_curr_pixel, sd_background, sd_variance);
        for (int i = 1; i < SD_LAT; i++) stg[i] <= stg[i-1];
    end
    assign {sd_background_next, sd_variance_next, sd_motion_detected} = stg[SD_LAT-1];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        pix;
        logic [7:0]        ob;
        logic [7:0]        ov;
        logic [7:0]        bg;
        logic [7:0]        vr;
        logic              mot;
        logic              last;
        logic              wrbg;
        logic              init;
        int                wb_cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_bg[NPIX];
    logic [7:0] ref_var[NPIX];
    int         pos = 0;
    int         frames = 0;
    logic       untracked = 1'b0;
    int         last_acc = 0;
    logic       last_init = 1'b0;
    logic       fd_prev = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        logic have, exp_rd, exp_sd, exp_wr;
        if (!rst) begin
            fd_prev <= 1'b0;
        end else begin
            if (frame_done || fd_prev) check("frame_done", 64'(frame_done), 64'(fd_prev));
            fd_prev <= 1'b0;
            if (!untracked) begin
                have = (q.size() > 0);
                if (have) e = q[0];
                exp_rd = have && !e.init && (cyc == e.wb_cyc - 1 - SD_LAT);
                exp_sd = have && !e.init && (cyc == e.wb_cyc - SD_LAT);
                exp_wr = have && (cyc == e.wb_cyc);
                if (mem_rd_en || exp_rd) begin
                    check("mem_rd_en", 64'(mem_rd_en), 64'(exp_rd));
                    if (exp_rd) check("rd_addr", 64'(mem_addr), 64'(e.addr));
                end
                if (sd_enable || exp_sd) begin
                    check("sd_enable", 64'(sd_enable), 64'(exp_sd));
                    if (exp_sd) begin
                        check("sd_curr_pixel", 64'(sd_curr_pixel), 64'(e.pix));
                        check("sd_background", 64'(sd_background), 64'(e.ob));
                        check("sd_variance", 64'(sd_variance), 64'(e.ov));
                    end
                end
                if (mem_wr_en || mask_valid || exp_wr) begin
                    check("mem_wr_en", 64'(mem_wr_en), 64'(exp_wr));
                    check("mask_valid", 64'(mask_valid), 64'(exp_wr));
                    if (exp_wr) begin
                        void'(q.pop_front());
                        check("wr_addr", 64'(mem_addr), 64'(e.addr));
                        check("wr_bg", 64'(mem_wr_bg), 64'(e.bg));
                        check("wr_var", 64'(mem_wr_var), 64'(e.vr));
                        check("mask_bit", 64'(mask_bit), 64'(e.mot));
                        check("sd_wr_background", 64'(sd_wr_background), 64'(e.wrbg));
                        if (!e.init) begin
                            check("held_pixel", 64'(sd_curr_pixel), 64'(e.pix));
                            check("held_bg", 64'(sd_background), 64'(e.ob));
                        end
                        fd_prev <= e.last;
                    end
                end
            end
        end
    end

    task automatic send_pixel(input logic [7:0] d, input logic s, input logic track,
                              input logic chk_gap);
        exp_t e;
        int   a;
        int   waited;
        logic [16:0] r;
        waited = 0;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        while (!pix_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!pix_ready) begin
            check("handshake_timeout", 64'(waited), 64'(0));
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            return;
        end
        if (chk_gap) check("accept_spacing", 64'(cyc - last_acc),
                           64'(last_init ? 2 : 3 + SD_LAT));
        last_acc = cyc;
        if (track) begin
            a      = s ? 0 : pos;
            e.addr = ADDR_W'(a);
            e.pix  = d;
            e.ob   = ref_bg[a];
            e.ov   = ref_var[a];
`ifdef SD_CTRL_BG_INIT_EN
            e.init = (frames == 0);
`else
            e.init = 1'b0;
`endif
            r = e.init ? {d, 8'd1, 1'b0} : sd_ref(d, e.ob, e.ov);
            {e.bg, e.vr, e.mot} = r;
            e.last   = (a == NPIX - 1);
            e.wrbg   = ((frames % UPDATE_PERIOD) == 0);
            e.wb_cyc = cyc + (e.init ? 1 : 2 + SD_LAT);
            q.push_back(e);
            ref_bg[a]  = e.bg;
            ref_var[a] = e.vr;
            pos        = e.last ? 0 : a + 1;
            if (e.last) frames++;
            last_init = e.init;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({pix_ready, mem_addr, mem_rd_en, mem_wr_en, sd_enable,
                                   sd_wr_background, mask_valid, mask_bit, frame_done}), 64'(0));
        check({tag, "_data"}, 64'({mem_wr_bg, mem_wr_var, sd_curr_pixel, sd_background,
                                   sd_variance}), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NPIX; i++) begin
            seed_bg[i]  = 8'($urandom);
            seed_var[i] = 8'($urandom_range(1, 40));
        end
        seed_bg[0]  = 8'h40;
        seed_var[0] = 8'h02;
        for (int i = 0; i < NPIX; i++) begin
            ref_bg[i]  = seed_bg[i];
            ref_var[i] = seed_var[i];
        end

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        ram_load = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(pix_ready), 64'(1));
        check("wr_bg_after_reset", 64'(sd_wr_background), 64'(1));

        // Single known pixel at address 0.
        send_pixel(8'h80, 1'b1, 1'b1, 1'b0);
        drain();
`ifdef SD_CTRL_BG_INIT_EN
        check("ram0_bg", 64'(ram_bg[0]), 64'(8'h80));
        check("ram0_var", 64'(ram_var[0]), 64'(8'h01));
`else
        check("ram0_bg", 64'(ram_bg[0]), 64'(8'h41));
        check("ram0_var", 64'(ram_var[0]), 64'(8'h03));
`endif

        // Five back-to-back frames, sof only on the first pixel.
        for (int f = 0; f < 5; f++) begin
            for (int p = 0; p < NPIX; p++) begin
                send_pixel(8'($urandom), (p == 0), 1'b1, !(f == 0 && p == 0));
            end
        end

        // Start-of-frame arriving at the fourth pixel of a frame.
        for (int p = 0; p < 3; p++) send_pixel(8'($urandom), (p == 0), 1'b1, 1'b0);
        send_pixel(8'($urandom), 1'b1, 1'b1, 1'b0);

        // Random gaps and occasional stray start-of-frame.
        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_pixel(8'($urandom), ($urandom_range(0, 7) == 0), 1'b1, 1'b0);
        end
        drain();

        // Reset while the pixel is in the WAIT state.
        untracked = 1'b1;
        send_pixel(8'hA5, 1'b0, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!sd_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sd_enable_before_abort", 64'(sd_enable), 64'(1));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        untracked = 1'b0;
        pos       = 0;
        frames    = 0;
        repeat (2) @(negedge clk);

        for (int p = 0; p < NPIX + 2; p++) send_pixel(8'($urandom), 1'b0, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
